// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, pipeline FSM states, condition-code bit layout.
package lc3_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OPC_W  = 4;

   localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
   localparam logic [OPC_W-1:0] OP_LD  = 4'b0010;
   localparam logic [OPC_W-1:0] OP_ST  = 4'b0011;
   localparam logic [OPC_W-1:0] OP_AND = 4'b0101;
   localparam logic [OPC_W-1:0] OP_LDR = 4'b0110;
   localparam logic [OPC_W-1:0] OP_STR = 4'b0111;
   localparam logic [OPC_W-1:0] OP_NOT = 4'b1001;
   localparam logic [OPC_W-1:0] OP_LDI = 4'b1010;
   localparam logic [OPC_W-1:0] OP_STI = 4'b1011;
   localparam logic [OPC_W-1:0] OP_LEA = 4'b1110;

   // Condition codes are carried as {N,P,Z}
   localparam int unsigned NPZ_N = 2;
   localparam int unsigned NPZ_P = 1;
   localparam int unsigned NPZ_Z = 0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IND  = 3'd1,
      ST_GAP  = 3'd2,
      ST_ACC  = 3'd3,
      ST_FIN  = 3'd4
   } mem_state_e;

   typedef enum logic [2:0] {
      CL_NONE  = 3'd0,
      CL_ALU   = 3'd1,
      CL_LOAD  = 3'd2,
      CL_LDI   = 3'd3,
      CL_STORE = 3'd4,
      CL_STI   = 3'd5
   } op_class_e;

   function automatic op_class_e op_class(input logic [OPC_W-1:0] opc);
      op_class_e cls;
      cls = CL_NONE;
      case (opc)
         OP_ADD, OP_AND, OP_NOT, OP_LEA: cls = CL_ALU;
         OP_LD, OP_LDR:                  cls = CL_LOAD;
         OP_LDI:                         cls = CL_LDI;
         OP_ST, OP_STR:                  cls = CL_STORE;
         OP_STI:                         cls = CL_STI;
         default:                        cls = CL_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/npz_gen.sv
// Condition-code generator: 16-bit value -> one-hot {N,P,Z}.
module npz_gen
   import lc3_pkg::*;
(
   input  logic [DATA_W-1:0] value,
   output logic [2:0]        npz_c
);

   always_comb begin
      npz_c = 3'b000;
      if (value[DATA_W-1])
         npz_c[NPZ_N] = 1'b1;
      else if (value == '0)
         npz_c[NPZ_Z] = 1'b1;
      else
         npz_c[NPZ_P] = 1'b1;
   end

endmodule

// File: rtl/mem_access.sv
// LC-3 memory-access/writeback stage: runs the data-memory transaction for
// the captured instruction and reports the register writeback with a DONE pulse.
module mem_access
   import lc3_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 255
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] ir,
   input  logic [DATA_W-1:0] alu_y,
   input  logic [DATA_W-1:0] sr_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              wb_en,
   output logic [DATA_W-1:0] wb_data,
   output logic [2:0]        wb_npz,
   output logic              err
);

   localparam int unsigned     CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   mem_state_e        state_q, state_d;
   op_class_e         cls_q, cls_in_c, cls_eff_c;
   logic [DATA_W-1:0] addr_q, wdata_q, wb_next_c;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        npz_next_c;
   logic              accept_c, waiting_c, expire_c, wb_en_next_c;
   logic              unused_ir;

   assign unused_ir = ^ir[DATA_W-OPC_W-1:0];
   assign cls_in_c  = op_class(ir[DATA_W-1:DATA_W-OPC_W]);
   assign accept_c  = (state_q == ST_IDLE) && start;
   assign waiting_c = ((state_q == ST_IND) || (state_q == ST_ACC)) && !mem_ready;
   // READY takes priority: expiry only fires on a cycle that is still waiting
   assign expire_c  = (WAIT_MAX != 0) && waiting_c && (cnt_q == CNT_LAST);

   assign cls_eff_c    = (state_q == ST_IDLE) ? cls_in_c : cls_q;
   assign wb_next_c    = (state_q == ST_IDLE) ? alu_y : mem_rdata;
   assign wb_en_next_c = (cls_eff_c == CL_ALU) || (cls_eff_c == CL_LOAD) || (cls_eff_c == CL_LDI);

   npz_gen u_npz (
      .value (wb_next_c),
      .npz_c (npz_next_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (cls_in_c)
                  CL_LDI, CL_STI:   state_d = ST_IND;
                  CL_LOAD, CL_STORE: state_d = ST_ACC;
                  default:          state_d = ST_FIN;
               endcase
            end
         end
         ST_IND: begin
            if (mem_ready)     state_d = ST_GAP;
            else if (expire_c) state_d = ST_IDLE;
         end
         ST_GAP:  state_d = ST_ACC;
         ST_ACC: begin
            if (mem_ready)     state_d = ST_FIN;
            else if (expire_c) state_d = ST_IDLE;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_FIN);
      mem_req = (state_q == ST_IND) || (state_q == ST_ACC);
      mem_we  = (state_q == ST_ACC) && ((cls_q == CL_STORE) || (cls_q == CL_STI));
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // Capture, pointer latch, wait counter, error flag and writeback registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cls_q   <= CL_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         err     <= 1'b0;
         wb_en   <= 1'b0;
         wb_data <= '0;
         wb_npz  <= 3'b000;
      end else begin
         cnt_q <= waiting_c ? (cnt_q + CNT_W'(1)) : '0;
         if (accept_c) begin
            cls_q   <= cls_in_c;
            addr_q  <= alu_y;
            wdata_q <= sr_data;
            err     <= 1'b0;
         end
         if ((state_q == ST_IND) && mem_ready)
            addr_q <= mem_rdata;
         if (expire_c)
            err <= 1'b1;
         if (state_d == ST_FIN) begin
            wb_en <= wb_en_next_c;
            if (wb_en_next_c) begin
               wb_data <= wb_next_c;
               wb_npz  <= npz_next_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table plus reset, timeout and
// start-while-busy sequences against a stalling memory responder.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] ir = '0, alu_y = '0, sr_data = '0;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'hDEAD;
   logic        mem_ready = 1'b0;
   logic        busy, done, wb_en, err;
   logic [15:0] wb_data;
   logic [2:0]  wb_npz;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access #(.WAIT_MAX(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .ir        (ir),
      .alu_y     (alu_y),
      .sr_data   (sr_data),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done),
      .wb_en     (wb_en),
      .wb_data   (wb_data),
      .wb_npz    (wb_npz),
      .err       (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder: per-request stall counts from a queue, access log
   logic [15:0] mem [logic [15:0]];
   int          stalls[$];
   logic [15:0] acc_addr[$];
   logic        acc_we[$];
   bit          in_req = 1'b0;
   int          waited = 0, cur_stall = 0;
   logic [15:0] req_addr, req_wd;
   logic        req_we;

   always @(negedge clk) begin
      if (!mem_req) begin
         mem_ready = 1'b0;
         mem_rdata = 16'hDEAD;
         in_req    = 1'b0;
      end else begin
         if (!in_req) begin
            in_req    = 1'b1;
            waited    = 0;
            cur_stall = (stalls.size() > 0) ? stalls.pop_front() : 0;
            req_addr  = mem_addr;
            req_we    = mem_we;
            req_wd    = mem_wdata;
         end else begin
            chk("stable_addr", 32'(mem_addr), 32'(req_addr));
            chk("stable_we", 32'(mem_we), 32'(req_we));
            chk("stable_wdata", 32'(mem_wdata), 32'(req_wd));
         end
         if (waited >= cur_stall) begin
            mem_ready = 1'b1;
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
            acc_addr.push_back(mem_addr);
            acc_we.push_back(mem_we);
            if (mem_we) mem[mem_addr] = mem_wdata;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 16'hDEAD;
            waited++;
         end
      end
   end

   // Issues one START and returns the DONE cycle (-1 if none within budget)
   task automatic run_op(input logic [15:0] i_ir, input logic [15:0] a, input logic [15:0] s,
                         output int cyc);
      @(negedge clk);
      ir = i_ir; alu_y = a; sr_data = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   typedef struct {
      logic [15:0] ir, alu, sr;
      int          stall0, stall1;
      int          cyc;
      logic        en;
      logic [15:0] data;
      logic [2:0]  npz;
      int          nacc;
      logic [15:0] a0, a1;
      logic        we;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int cyc, ndone, nreq, first;

      vecs[0] = '{16'h1000, 16'hFFFE, 16'h0000, 0, 0, 1, 1'b1, 16'hFFFE, 3'b100, 0, 16'h0, 16'h0, 1'b0};
      vecs[1] = '{16'h5000, 16'h0000, 16'h0000, 0, 0, 1, 1'b1, 16'h0000, 3'b001, 0, 16'h0, 16'h0, 1'b0};
      vecs[2] = '{16'hE000, 16'h1234, 16'h0000, 0, 0, 1, 1'b1, 16'h1234, 3'b010, 0, 16'h0, 16'h0, 1'b0};
      vecs[3] = '{16'h9000, 16'h7FFF, 16'h0000, 0, 0, 1, 1'b1, 16'h7FFF, 3'b010, 0, 16'h0, 16'h0, 1'b0};
      vecs[4] = '{16'hD000, 16'h7777, 16'h0000, 0, 0, 1, 1'b0, 16'h0000, 3'b000, 0, 16'h0, 16'h0, 1'b0};
      vecs[5] = '{16'h2000, 16'h0100, 16'h0000, 0, 0, 2, 1'b1, 16'h8000, 3'b100, 1, 16'h0100, 16'h0, 1'b0};
      vecs[6] = '{16'h6000, 16'h0101, 16'h0000, 2, 0, 4, 1'b1, 16'h0000, 3'b001, 1, 16'h0101, 16'h0, 1'b0};
      vecs[7] = '{16'hA000, 16'h3000, 16'h0000, 0, 0, 4, 1'b1, 16'h0005, 3'b010, 2, 16'h3000, 16'h4000, 1'b0};
      vecs[8] = '{16'h3000, 16'h0200, 16'h1111, 1, 0, 3, 1'b0, 16'h0000, 3'b000, 1, 16'h0200, 16'h0, 1'b1};
      vecs[9] = '{16'hB000, 16'h3000, 16'hABCD, 0, 3, 7, 1'b0, 16'h0000, 3'b000, 2, 16'h3000, 16'h4000, 1'b1};

      mem[16'h0100] = 16'h8000;
      mem[16'h0101] = 16'h0000;
      mem[16'h3000] = 16'h4000;
      mem[16'h4000] = 16'h0005;

      #2;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_npz", 32'(wb_npz), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         stalls.delete();
         stalls.push_back(vecs[i].stall0);
         stalls.push_back(vecs[i].stall1);
         acc_addr.delete();
         acc_we.delete();
         run_op(vecs[i].ir, vecs[i].alu, vecs[i].sr, cyc);
         chk($sformatf("v%0d done_cycle", i), 32'(cyc), 32'(vecs[i].cyc));
         chk($sformatf("v%0d busy_at_done", i), 32'(busy), 32'd1);
         chk($sformatf("v%0d wb_en", i), 32'(wb_en), 32'(vecs[i].en));
         if (vecs[i].en) begin
            chk($sformatf("v%0d wb_data", i), 32'(wb_data), 32'(vecs[i].data));
            chk($sformatf("v%0d wb_npz", i), 32'(wb_npz), 32'(vecs[i].npz));
         end
         chk($sformatf("v%0d n_access", i), 32'(acc_addr.size()), 32'(vecs[i].nacc));
         if (acc_addr.size() >= 1 && vecs[i].nacc >= 1) begin
            chk($sformatf("v%0d addr0", i), 32'(acc_addr[0]), 32'(vecs[i].a0));
            chk($sformatf("v%0d last_we", i), 32'(acc_we[acc_we.size()-1]), 32'(vecs[i].we));
         end
         if (acc_addr.size() >= 2 && vecs[i].nacc >= 2)
            chk($sformatf("v%0d addr1", i), 32'(acc_addr[1]), 32'(vecs[i].a1));
         @(negedge clk);
         chk($sformatf("v%0d done_single", i), 32'(done), 32'd0);
         chk($sformatf("v%0d busy_after", i), 32'(busy), 32'd0);
      end
      chk("st_mem", 32'(mem[16'h0200]), 32'h1111);
      chk("sti_mem", 32'(mem[16'h4000]), 32'hABCD);

      // Timeout: store whose READY never arrives
      stalls.delete();
      stalls.push_back(1000);
      @(negedge clk);
      ir = 16'h3000; alu_y = 16'h0300; sr_data = 16'h2222; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nreq = 0; ndone = 0;
      while (mem_req && nreq < 20) begin
         nreq++;
         if (done) ndone++;
         @(negedge clk);
      end
      chk("to_req_cycles", 32'(nreq), 32'd4);
      chk("to_err", 32'(err), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_done", 32'(ndone + 32'(done)), 32'd0);
      chk("to_wb_en_held", 32'(wb_en), 32'd0);
      stalls.delete();
      run_op(16'h1000, 16'h0042, 16'h0000, cyc);
      chk("to_next_cycle", 32'(cyc), 32'd1);
      chk("to_err_cleared", 32'(err), 32'd0);
      chk("to_next_data", 32'(wb_data), 32'h0042);
      @(negedge clk);

      // START pulsed while an LD is waiting on memory
      stalls.delete();
      stalls.push_back(2);
      acc_addr.delete();
      acc_we.delete();
      @(negedge clk);
      ir = 16'h2000; alu_y = 16'h0100; sr_data = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      ir = 16'h1000; alu_y = 16'h0055; start = 1'b1;
      ndone = 0; first = -1;
      for (int c = 2; c < 14; c++) begin
         if (done) begin
            ndone++;
            if (first < 0) first = c;
         end
         @(negedge clk);
         start = 1'b0;
      end
      chk("busy_start_done_count", 32'(ndone), 32'd1);
      chk("busy_start_done_cycle", 32'(first), 32'd4);
      chk("busy_start_access_count", 32'(acc_addr.size()), 32'd1);
      chk("busy_start_wb_data", 32'(wb_data), 32'h8000);
      chk("busy_start_wb_npz", 32'(wb_npz), 32'b100);

      // Reset asserted mid-access while REQ is high
      stalls.delete();
      stalls.push_back(3);
      @(negedge clk);
      ir = 16'h2000; alu_y = 16'h0100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("mid_req_high", 32'(mem_req), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_req_async_low", 32'(mem_req), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      stalls.delete();
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("mid_no_done", 32'(ndone), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_npz", 32'(wb_npz), 32'd0);
      chk("mid_wb_en", 32'(wb_en), 32'd0);
      chk("mid_req", 32'(mem_req), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

LC-3 memory-access/writeback stage, directly downstream of the execution stage. Captures the decoded instruction and the ALU result (effective address or arithmetic result) on a start pulse. Runs the data-memory transaction: single read/write, or two accesses for indirect LDI/STI. Presents the register-file writeback value and condition codes with a one-cycle done pulse.

## Interface
- WAIT_MAX, 255: max cycles MEM_REQ may wait for MEM_READY before abort; 0 disables timeout.
- CLK  in  1  sole clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse: IR/ALU_Y/SR_DATA valid; ignored while BUSY.
- IR  in  16  instruction; opcode IR[15:12].
- ALU_Y  in  16  execution-stage result (address for memory ops, value otherwise).
- SR_DATA  in  16  store source register data (R[IR[11:9]]).
- MEM_REQ  out  1  memory request.
- MEM_WE  out  1  1 = write, 0 = read; valid with MEM_REQ.
- MEM_ADDR  out  16  word address.
- MEM_WDATA  out  16  write data.
- MEM_RDATA  in  16  read data, valid when MEM_READY high.
- MEM_READY  in  1  transfer completes on the edge where MEM_REQ & MEM_READY.
- BUSY  out  1  high from cycle after START until DONE cycle inclusive.
- DONE  out  1  one-cycle completion pulse.
- WB_EN  out  1  write WB_DATA to R[IR[11:9]]; valid only with DONE.
- WB_DATA  out  16  writeback value.
- WB_NPZ  out  3  {N,P,Z} of WB_DATA; valid with DONE when WB_EN.
- ERR  out  1  timeout abort; sticky until next accepted START or reset.

## Operation
- Reset: state IDLE; all outputs 0 (MEM_* 0, BUSY/DONE/WB_EN/ERR 0, WB_NPZ 3'b000). MEM_REQ drops asynchronously on reset assertion, including mid-transaction; no completion reported.
- START in IDLE registers IR, ALU_Y, SR_DATA, clears ERR, sets BUSY.
- Opcode classes:
  - ADD 0001, AND 0101, NOT 1001, LEA 1110: no memory access; WB_DATA=ALU_Y, WB_EN=1.
  - LD 0010, LDR 0110: read at ALU_Y; WB_DATA=MEM_RDATA, WB_EN=1.
  - LDI 1010: read pointer at ALU_Y, then read at pointer; WB_DATA=second read.
  - ST 0011, STR 0111: write SR_DATA at ALU_Y; WB_EN=0.
  - STI 1011: read pointer at ALU_Y, write SR_DATA at pointer; WB_EN=0.
  - All other opcodes: no access, WB_EN=0.
- States: IDLE -> IND (LDI/STI) | ACC (other memory ops) | FIN (no access). IND -> ACC on READY, pointer latched into address register. ACC -> FIN on READY, read data latched. FIN -> IDLE unconditionally.
- DONE=1 only in FIN; WB_DATA/WB_EN/WB_NPZ registered, held until next DONE.
- WB_NPZ: N=WB_DATA[15]; Z=(WB_DATA==0); P otherwise; exactly one bit set.
- Handshake: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA stable while REQ high and READY low. REQ deasserts the cycle after the accepting edge, for at least one cycle between IND and ACC.
- Timeout: counter clears on entering IND/ACC, increments each REQ-high/READY-low cycle. When it reaches WAIT_MAX (WAIT_MAX>0): drop REQ, ERR=1, go IDLE, no DONE, no writeback. READY on the same edge as expiry wins.
- START while BUSY ignored, no side effect. START in FIN cycle also ignored.

## Timing
- Non-memory op: START at cycle 0, DONE at cycle 1.
- Single access, READY immediate: REQ cycle 1, DONE cycle 2. Each READY-low cycle adds one.
- Indirect, READY immediate: REQ cycle 1 (pointer), idle cycle 2, REQ cycle 3, DONE cycle 4.
- Back-to-back: earliest next START accepted is the cycle after DONE.

## Structure
- Shared package lc3_pkg: opcode constants (OP_ADD…OP_LEA), FSM state enum, NPZ bit-index constants. Execution and control stages import the same package.
- One sub-module: npz_gen (16-bit value -> {N,P,Z}), reusable by the execution stage.
- Remainder (FSM, timeout counter, capture/writeback registers) in mem_access.

## Test plan
- Reset mid-ACC with REQ high: REQ low same cycle; after release, BUSY=0, DONE never pulses, WB_NPZ=000.
- ADD, ALU_Y=16'hFFFE: DONE cycle 1, WB_EN=1, WB_DATA=FFFE, WB_NPZ=100. ALU_Y=0 gives WB_NPZ=001.
- LDI, ALU_Y=3000, mem[3000]=4000, mem[4000]=0005, READY immediate: addresses 3000 then 4000, DONE cycle 4, WB_DATA=0005, WB_NPZ=010.
- STI, mem[3000]=4000, SR_DATA=ABCD, READY low 3 cycles on second access: write at 4000 with WDATA stable across waits; DONE cycle 7, WB_EN=0.
- WAIT_MAX=4, ST with READY never high: REQ drops after 4 wait cycles, ERR=1, no DONE; next START clears ERR.
- START pulsed during LD wait: ignored, single transaction, single DONE.
